bpsk_frame_sequencer: RTL and testbench
=======================================

// Module: bpsk_frame_sequencer
// PURPOSE
//  Feeds the BPSK phase generator one symbol bit per wavelength.
//  Accepts payload bytes over a valid/ready stream and builds a frame: preamble, then payload MSB-first, then tail.
//  Frame boundaries are marked by in_last. Paces itself on the generator's next toggle.
//  Sits between the byte source and the phase generator; data_bit drives the generator's data input.
// PARAMETERS
//  PREAMBLE_LEN  16  preamble symbols, alternating 1,0,1,0... starting with 1; range 1..255
//  TAIL_LEN      4   tail symbols of 0 after the last payload bit; range 1..255
// PORTS
//  clock         in   1  system clock; all logic on posedge
//  reset         in   1  synchronous, active-high reset
//  next_toggle   in   1  next output of phase generator; each level change = one symbol boundary
//  in_data       in   8  payload byte
//  in_last       in   1  in_data is the final byte of the frame
//  in_valid      in   1  in_data/in_last valid
//  in_ready      out  1  byte accepted when in_valid && in_ready
//  data_bit      out  1  current symbol bit to phase generator
//  tx_active     out  1  high in PREAMBLE, PAYLOAD and TAIL
//  frame_done    out  1  one-cycle pulse at the end of TAIL
//  underrun      out  1  one-cycle pulse: byte boundary with empty buffer and no in_last seen
// BEHAVIOUR
//  Reset: state IDLE; data_bit=0, tx_active=0, frame_done=0, underrun=0.
//   Buffer empties (in_ready=1 in the cycle after reset). nxt_q loads next_toggle, so no spurious strobe.
//  Strobe: sym = next_toggle ^ nxt_q; nxt_q <= next_toggle every cycle.
//   All state and data_bit changes occur only on sym cycles and are visible 1 cycle later (registered).
//  Buffer: one entry {byte, last}. in_ready = ~buf_valid (from registers only).
//   Loading the buffer into the shift register frees it: in_ready is 1 in the next cycle.
//   If accept and unload happen in the same cycle, the incoming byte is kept and buf_valid stays 1.
//  IDLE: data_bit=0.
//   sym && buf_valid -> PREAMBLE; cnt=0; data_bit=1.
//   No buf_valid: stay IDLE.
//  PREAMBLE: data_bit = ~cnt[0]. On each sym: cnt++.
//   When cnt==PREAMBLE_LEN-1 and sym: load shreg<=buf, last_q<=buf.last, free buffer, data_bit=buf[7], -> PAYLOAD, bitn=0.
//   buf_valid is guaranteed in PREAMBLE (entry held since IDLE).
//  PAYLOAD: data_bit = shreg[7-bitn]. On sym with bitn<7: bitn++.
//   On sym with bitn==7:
//   - last_q=1 -> TAIL, cnt=0, data_bit=0.
//   - buf_valid -> load next byte, bitn=0 (no gap between bytes).
//   - else -> underrun pulse, TAIL, cnt=0 (frame truncated).
//  TAIL: data_bit=0. On sym: cnt++.
//   When cnt==TAIL_LEN-1 and sym: frame_done pulse, -> IDLE.
//   A byte waiting in the buffer starts a new frame only at the next sym after IDLE is reached (min 1 idle symbol).
//  Bytes are accepted in any state, including ahead of the next frame.
//  Reset mid-frame: frame aborted immediately, buffered byte dropped, no frame_done/underrun pulse.
//  Counters: cnt is 8 bit, bitn is 3 bit. No wrap is reachable within the legal parameter range.
// STRUCTURE
//  bpsk_pkg:
//   - typedef enum logic[1:0] {IDLE, PREAMBLE, PAYLOAD, TAIL} seq_state_t
//   - localparam BYTE_W=8
//  Sub-module bpsk_byte_buffer: one-entry valid/ready holding register with a pop input.
//  Strobe detect, FSM and shift register stay in this module.
// TESTING
//  Bench model: next_toggle flips every 8 clocks (WAVELENGTH=8). PREAMBLE_LEN=4, TAIL_LEN=2.
//  1. Single byte 0xA5, last=1 -> data_bit per symbol 1,0,1,0, 1,0,1,0,0,1,0,1, 0,0.
//     frame_done pulses once after 14 symbols; tx_active high for exactly 14 symbols.
//  2. Two bytes 0xFF, 0x00(last) fed back-to-back -> 8 ones then 8 zeros, no gap symbol, no underrun.
//  3. Byte 0x81 with last=0, no follow-up -> bits 1,0,0,0,0,0,0,1.
//     underrun pulses 1 cycle at the 8th-bit boundary, then 2 tail zeros, then frame_done.
//  4. in_valid held high with 3 bytes -> in_ready low while buffer full.
//     Each byte is accepted exactly once, in order; no byte lost or duplicated (scoreboard).
//  5. reset asserted for 1 cycle mid-PAYLOAD -> next cycle: data_bit=0, tx_active=0, in_ready=1.
//     No frame_done. A new byte then starts with a full preamble.
//  6. next_toggle frozen for 100 clocks mid-frame -> data_bit and state unchanged; resumes on the next toggle.

Source files
------------

// File: rtl/bpsk_pkg.sv
// Shared types for the BPSK frame sequencer.
// State encoding and byte width.
package bpsk_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    TAIL
  } seq_state_t;

endpackage

// File: rtl/bpsk_byte_buffer.sv
// One-entry byte holding register.
// Valid/ready on the input side, pop on the output side.
module bpsk_byte_buffer
  import bpsk_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              pop,
  output logic              buf_valid,
  output logic [BYTE_W-1:0] buf_data,
  output logic              buf_last
);

  logic              valid_q, valid_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  assign in_ready  = ~valid_q;
  assign buf_valid = valid_q;
  assign buf_data  = data_q;
  assign buf_last  = last_q;

  // Pop frees the entry; an accept in the same cycle keeps it full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (pop) valid_d = 1'b0;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
    end
  end

  // Entry register.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/bpsk_frame_sequencer.sv
// Frame sequencer: preamble, MSB-first payload, tail.
// Advances one symbol per level change of next_toggle.
module bpsk_frame_sequencer
  import bpsk_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 16,
  parameter int unsigned TAIL_LEN     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              next_toggle,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              data_bit,
  output logic              tx_active,
  output logic              frame_done,
  output logic              underrun
);

  localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] TAIL_LAST = 8'(TAIL_LEN - 1);

  seq_state_t        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        bitn_q, bitn_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic              last_q, last_d;
  logic              bit_q, bit_d;
  logic              done_q, done_d;
  logic              urun_q, urun_d;
  logic              nxt_q;
  logic              sym;
  logic              pop;
  logic              buf_valid;
  logic [BYTE_W-1:0] buf_data;
  logic              buf_last;

  bpsk_byte_buffer u_buf (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pop       (pop),
    .buf_valid (buf_valid),
    .buf_data  (buf_data),
    .buf_last  (buf_last)
  );

  assign sym        = next_toggle ^ nxt_q;
  assign data_bit   = bit_q;
  assign tx_active  = (state_q != IDLE);
  assign frame_done = done_q;
  assign underrun   = urun_q;

  // Next-state logic: everything moves only on a symbol strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    urun_d  = 1'b0;
    pop     = 1'b0;
    if (sym) begin
      unique case (state_q)
        IDLE: begin
          bit_d = 1'b0;
          if (buf_valid) begin
            state_d = PREAMBLE;
            cnt_d   = 8'd0;
            bit_d   = 1'b1;
          end
        end
        PREAMBLE: begin
          if (cnt_q == PRE_LAST) begin
            shreg_d = buf_data;
            last_d  = buf_last;
            pop     = 1'b1;
            bit_d   = buf_data[BYTE_W-1];
            bitn_d  = 3'd0;
            state_d = PAYLOAD;
          end else begin
            cnt_d = cnt_q + 8'd1;
            bit_d = cnt_q[0];
          end
        end
        PAYLOAD: begin
          if (bitn_q != 3'd7) begin
            bitn_d = bitn_q + 3'd1;
            bit_d  = shreg_q[3'd6 - bitn_q];
          end else if (last_q) begin
            state_d = TAIL;
            cnt_d   = 8'd0;
            bit_d   = 1'b0;
          end else if (buf_valid) begin
            shreg_d = buf_data;
            last_d  = buf_last;
            pop     = 1'b1;
            bit_d   = buf_data[BYTE_W-1];
            bitn_d  = 3'd0;
          end else begin
            urun_d  = 1'b1;
            state_d = TAIL;
            cnt_d   = 8'd0;
            bit_d   = 1'b0;
          end
        end
        TAIL: begin
          bit_d = 1'b0;
          if (cnt_q == TAIL_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer registers; nxt_q tracks next_toggle even in reset.
  always_ff @(posedge clock) begin
    nxt_q <= next_toggle;
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bitn_q  <= 3'd0;
      shreg_q <= '0;
      last_q  <= 1'b0;
      bit_q   <= 1'b0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      urun_q  <= urun_d;
    end
  end

endmodule

// File: tb/tb_bpsk_frame_sequencer.sv
// Directed bench for the BPSK frame sequencer.
// One symbol = 8 clocks of next_toggle; preamble 4, tail 2.
module tb_bpsk_frame_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       next_toggle = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       data_bit;
  logic       tx_active;
  logic       frame_done;
  logic       underrun;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int ur_cnt = 0;
  int act_cyc = 0;
  logic [63:0] got = '0;
  logic [8:0] pend[$];
  logic [7:0] acc_log[$];

  bpsk_frame_sequencer #(
    .PREAMBLE_LEN (4),
    .TAIL_LEN     (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .next_toggle (next_toggle),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_bit    (data_bit),
    .tx_active   (tx_active),
    .frame_done  (frame_done),
    .underrun    (underrun)
  );

  always #5 clock = ~clock;

  task automatic drive();
    if (pend.size() != 0) begin
      in_valid = 1'b1;
      {in_last, in_data} = pend[0];
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    pend.push_back({l, d});
    drive();
  endtask

  task automatic tick();
    logic acc;
    acc = in_valid && in_ready && !reset;
    @(posedge clock);
    #1;
    if (acc) begin
      acc_log.push_back(in_data);
      void'(pend.pop_front());
    end
    drive();
    if (frame_done) fd_cnt++;
    if (underrun) ur_cnt++;
    if (tx_active) act_cyc++;
  endtask

  task automatic step();
    next_toggle = ~next_toggle;
    tick();
    got = {got[62:0], data_bit};
    repeat (7) tick();
  endtask

  task automatic run(input int n);
    got = '0;
    repeat (n) step();
  endtask

  task automatic clr();
    fd_cnt = 0;
    ur_cnt = 0;
    act_cyc = 0;
    acc_log.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (data_bit !== 1'b0) begin
      failures++;
      $display("FAIL rst_data_bit got=%b exp=0", data_bit);
    end
    checks++;
    if (tx_active !== 1'b0) begin
      failures++;
      $display("FAIL rst_tx_active got=%b exp=0", tx_active);
    end
    checks++;
    if (frame_done !== 1'b0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL rst_pulses got=%b%b exp=00", frame_done, underrun);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_single_frame();
    clr();
    push(8'hA5, 1'b1);
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL t1_full_ready got=%b exp=0", in_ready);
    end
    run(14);
    checks++;
    if (got[13:0] !== 14'b10101010010100) begin
      failures++;
      $display("FAIL t1_bits got=%b exp=%b", got[13:0], 14'b10101010010100);
    end
    checks++;
    if (fd_cnt !== 0) begin
      failures++;
      $display("FAIL t1_early_done got=%0d exp=0", fd_cnt);
    end
    step();
    checks++;
    if (fd_cnt !== 1 || tx_active !== 1'b0 || data_bit !== 1'b0) begin
      failures++;
      $display("FAIL t1_end got=fd%0d tx%b bit%b exp=fd1 tx0 bit0",
               fd_cnt, tx_active, data_bit);
    end
    checks++;
    if (act_cyc !== 112) begin
      failures++;
      $display("FAIL t1_active_cycles got=%0d exp=112", act_cyc);
    end
    checks++;
    if (ur_cnt !== 0) begin
      failures++;
      $display("FAIL t1_underrun got=%0d exp=0", ur_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clr();
    push(8'hFF, 1'b0);
    push(8'h00, 1'b1);
    tick();
    run(22);
    checks++;
    if (got[21:0] !== {4'b1010, 8'hFF, 8'h00, 2'b00}) begin
      failures++;
      $display("FAIL t2_bits got=%b exp=%b", got[21:0],
               {4'b1010, 8'hFF, 8'h00, 2'b00});
    end
    step();
    checks++;
    if (fd_cnt !== 1 || ur_cnt !== 0 || tx_active !== 1'b0) begin
      failures++;
      $display("FAIL t2_end got=fd%0d ur%0d tx%b exp=fd1 ur0 tx0",
               fd_cnt, ur_cnt, tx_active);
    end
  endtask

  task automatic test_underrun();
    clr();
    push(8'h81, 1'b0);
    tick();
    run(12);
    checks++;
    if (got[11:0] !== {4'b1010, 8'h81}) begin
      failures++;
      $display("FAIL t3_bits got=%b exp=%b", got[11:0], {4'b1010, 8'h81});
    end
    checks++;
    if (ur_cnt !== 0) begin
      failures++;
      $display("FAIL t3_early_underrun got=%0d exp=0", ur_cnt);
    end
    step();
    checks++;
    if (ur_cnt !== 1 || data_bit !== 1'b0 || tx_active !== 1'b1) begin
      failures++;
      $display("FAIL t3_boundary got=ur%0d bit%b tx%b exp=ur1 bit0 tx1",
               ur_cnt, data_bit, tx_active);
    end
    step();
    checks++;
    if (fd_cnt !== 0 || data_bit !== 1'b0 || tx_active !== 1'b1) begin
      failures++;
      $display("FAIL t3_tail got=fd%0d bit%b tx%b exp=fd0 bit0 tx1",
               fd_cnt, data_bit, tx_active);
    end
    step();
    checks++;
    if (fd_cnt !== 1 || ur_cnt !== 1 || tx_active !== 1'b0) begin
      failures++;
      $display("FAIL t3_end got=fd%0d ur%0d tx%b exp=fd1 ur1 tx0",
               fd_cnt, ur_cnt, tx_active);
    end
  endtask

  task automatic test_backpressure();
    clr();
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b1);
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || in_valid !== 1'b1 || acc_log.size() != 1) begin
      failures++;
      $display("FAIL t4_stall got=rdy%b acc%0d exp=rdy0 acc1",
               in_ready, acc_log.size());
    end
    run(30);
    checks++;
    if (got[29:0] !== {4'b1010, 8'h11, 8'h22, 8'h33, 2'b00}) begin
      failures++;
      $display("FAIL t4_bits got=%b exp=%b", got[29:0],
               {4'b1010, 8'h11, 8'h22, 8'h33, 2'b00});
    end
    step();
    checks++;
    if (acc_log.size() != 3 || pend.size() != 0) begin
      failures++;
      $display("FAIL t4_accept_count got=%0d exp=3", acc_log.size());
    end else begin
      checks++;
      if (acc_log[0] !== 8'h11 || acc_log[1] !== 8'h22 ||
          acc_log[2] !== 8'h33) begin
        failures++;
        $display("FAIL t4_order got=%h %h %h exp=11 22 33",
                 acc_log[0], acc_log[1], acc_log[2]);
      end
    end
    checks++;
    if (fd_cnt !== 1 || ur_cnt !== 0) begin
      failures++;
      $display("FAIL t4_end got=fd%0d ur%0d exp=fd1 ur0", fd_cnt, ur_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    clr();
    push(8'hC3, 1'b1);
    push(8'h3C, 1'b1);
    tick();
    run(6);
    tick();
    checks++;
    if (in_ready !== 1'b0 || tx_active !== 1'b1) begin
      failures++;
      $display("FAIL t5_pre got=rdy%b tx%b exp=rdy0 tx1", in_ready, tx_active);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (data_bit !== 1'b0 || tx_active !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL t5_after_rst got=bit%b tx%b rdy%b exp=bit0 tx0 rdy1",
               data_bit, tx_active, in_ready);
    end
    clr();
    run(3);
    checks++;
    if (act_cyc !== 0 || fd_cnt !== 0 || ur_cnt !== 0) begin
      failures++;
      $display("FAIL t5_quiet got=act%0d fd%0d ur%0d exp=0 0 0",
               act_cyc, fd_cnt, ur_cnt);
    end
    push(8'h5A, 1'b1);
    tick();
    run(14);
    checks++;
    if (got[13:0] !== {4'b1010, 8'h5A, 2'b00}) begin
      failures++;
      $display("FAIL t5_new_frame got=%b exp=%b", got[13:0],
               {4'b1010, 8'h5A, 2'b00});
    end
    step();
    checks++;
    if (fd_cnt !== 1 || tx_active !== 1'b0) begin
      failures++;
      $display("FAIL t5_end got=fd%0d tx%b exp=fd1 tx0", fd_cnt, tx_active);
    end
  endtask

  task automatic test_freeze();
    logic hold;
    int bad;
    clr();
    push(8'h96, 1'b1);
    tick();
    run(6);
    hold = data_bit;
    bad = 0;
    repeat (100) begin
      tick();
      if (data_bit !== hold || tx_active !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL t6_frozen got=%0d changed cycles exp=0", bad);
    end
    repeat (8) step();
    checks++;
    if (got[13:0] !== {4'b1010, 8'h96, 2'b00}) begin
      failures++;
      $display("FAIL t6_bits got=%b exp=%b", got[13:0],
               {4'b1010, 8'h96, 2'b00});
    end
    step();
    checks++;
    if (fd_cnt !== 1 || ur_cnt !== 0 || tx_active !== 1'b0) begin
      failures++;
      $display("FAIL t6_end got=fd%0d ur%0d tx%b exp=fd1 ur0 tx0",
               fd_cnt, ur_cnt, tx_active);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_backpressure();
    test_reset_mid_frame();
    test_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
